adder_arb: RTL and testbench
============================

ADDER_ARB -- requirements
Module: adder_arb

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 1, legal range 1..15: cycles the external ripple adder is given to settle before its result is sampled.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-004 SHALL have ports req0_valid / req1_valid, input, 1 each, requester operand-valid.
REQ-005 SHALL have ports req0_a, req0_b, req1_a, req1_b, input, 16 each, requester operands.
REQ-006 SHALL have ports req0_ready / req1_ready, output, 1 each, accept strobe per requester.
REQ-007 SHALL have ports add_a / add_b, output, 16 each, operands driven to the shared 16-bit adder.
REQ-008 SHALL have ports add_s (input, 16) and add_co (input, 1), sum and carry-out returned from the shared adder.
REQ-009 SHALL have ports rsp_valid (output, 1), rsp_id (output, 1: 0 = req0, 1 = req1), rsp_sum (output, 16), rsp_co (output, 1), plus rsp_ready (input, 1).

Function
REQ-010 SHALL implement FSM states IDLE, SETTLE and RESP.
REQ-011 In IDLE, SHALL assert exactly one of req0_ready/req1_ready, the current grant, combinationally when that requester's valid is high; no ready SHALL be asserted outside IDLE.
REQ-012 Arbitration SHALL be round-robin: a sole valid requester wins; with both valid, the requester not granted last wins; last-grant pointer resets to 1 so req0 wins first.
REQ-013 On an accept edge (granted valid && ready), SHALL register the operands into add_a/add_b, record rsp_id, update the last-grant pointer, load the settle counter with SETTLE_CYC-1 and enter SETTLE.
REQ-014 add_a/add_b SHALL hold constant from accept until the next accept.
REQ-015 In SETTLE, SHALL decrement the counter each cycle; at the edge where the counter is 0, SHALL capture add_s/add_co into rsp_sum/rsp_co and enter RESP.
REQ-016 Latency: rsp_valid SHALL rise exactly SETTLE_CYC cycles after the accept edge.
REQ-017 In RESP, SHALL hold rsp_valid=1 with rsp_id/rsp_sum/rsp_co stable until rsp_ready=1, then at that edge clear rsp_valid and return to IDLE.
REQ-018 Throughput SHALL be one add per SETTLE_CYC+2 cycles with rsp_ready tied high and continuous requests.
REQ-019 Arithmetic SHALL be unsigned 16-bit modulo 2^16; rsp_co SHALL equal the raw adder carry-out.
REQ-020 Requester valid changes during SETTLE/RESP SHALL be ignored; a request dropped before acceptance SHALL not be serviced.

Reset
REQ-021 While rst_n=0 at a clock edge: state=IDLE, add_a=add_b=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_co=0, counter=0, last-grant=1; req*_ready SHALL be 0 during reset.
REQ-022 Reset asserted mid-operation (SETTLE or RESP) SHALL abandon the in-flight add with no response issued.

Configuration
REQ-023 With macro ADDER_ARB_SAT_EN defined, rsp_sum SHALL saturate to 16'hFFFF whenever the captured add_co=1 (rsp_co still 1); without it, rsp_sum SHALL be the raw add_s.

Verification
REQ-024 Reset: hold rst_n=0 two cycles with both valids high -> all outputs 0, no ready until the first cycle after release.
REQ-025 Single add, SETTLE_CYC=1: req0 0x1234+0x0001, rsp_ready=1 -> rsp_valid one cycle after accept, rsp_sum=0x1235, rsp_co=0, rsp_id=0.
REQ-026 Both valid continuously: req0 0x0001+0x0001, req1 0x0002+0x0002 -> grants alternate req0, req1, req0; responses 0x0002, 0x0004, 0x0002.
REQ-027 Overflow: req1 0xFFFF+0x0002 -> rsp_sum=0x0001, rsp_co=1; with ADDER_ARB_SAT_EN, rsp_sum=0xFFFF, rsp_co=1.
REQ-028 Backpressure, SETTLE_CYC=4: rsp_ready low 5 cycles -> rsp_valid rises 4 cycles after accept, outputs stable, no new ready until after rsp_ready handshake.
REQ-029 Reset mid-SETTLE: accept req0, drop rst_n for one cycle during SETTLE -> no rsp_valid, FSM in IDLE, req0 granted first.

Source files
------------

// File: rtl/adder_arb.sv
// -----------------------------------------------------------------------------
// adder_arb
//
// Two-requester round-robin front end for one shared external 16-bit ripple
// adder. A granted request's operands are registered onto add_a/add_b. The
// adder is then given SETTLE_CYC cycles to settle, and its sum/carry are
// sampled. The result is presented on the rsp_* handshake until rsp_ready
// accepts it.
//
// Parameters:
//   SETTLE_CYC  cycles the external adder is given to settle (1..15)
//
// Configuration macro:
//   ADDER_ARB_SAT_EN  when defined, rsp_sum saturates to 16'hFFFF whenever
//                     the captured carry-out is 1 (rsp_co still reports 1)
//
// Ports:
//   clk                      single clock, rising edge
//   rst_n                    synchronous active-low reset
//   req0_valid, req1_valid   requester operand-valid
//   req0_a, req0_b           requester 0 operands (16 bit)
//   req1_a, req1_b           requester 1 operands (16 bit)
//   req0_ready, req1_ready   accept strobe per requester (IDLE only)
//   add_a, add_b             operands driven to the shared adder
//   add_s, add_co            sum and carry-out returned by the shared adder
//   rsp_valid                response valid
//   rsp_id                   0 = req0, 1 = req1
//   rsp_sum, rsp_co          captured sum and carry-out
//   rsp_ready                response accept from the consumer
// -----------------------------------------------------------------------------
module adder_arb #(
    parameter int SETTLE_CYC = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic        req1_valid,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    output logic        req0_ready,
    output logic        req1_ready,
    output logic [15:0] add_a,
    output logic [15:0] add_b,
    input  logic [15:0] add_s,
    input  logic        add_co,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [15:0] rsp_sum,
    output logic        rsp_co,
    input  logic        rsp_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Counter counts down to zero, so SETTLE_CYC-1 gives SETTLE_CYC sample edges.
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);

    state_t      state;
    state_t      next_state;
    logic [3:0]  settle_cnt;
    logic        last_grant;
    logic        grant;
    logic        accept;
    logic [15:0] sum_capture;

`ifdef ADDER_ARB_SAT_EN
    assign sum_capture = add_co ? 16'hFFFF : add_s;
`else
    assign sum_capture = add_s;
`endif

    assign rsp_valid = (state == RESP);

    // Grant: a sole valid requester wins. When both are valid, the requester
    // not granted last time wins. Ready is gated with rst_n so that neither
    // requester sees an accept strobe while reset is held.
    always_comb begin
        grant      = ~last_grant;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        next_state = state;

        if (req0_valid && !req1_valid) begin
            grant = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            grant = 1'b1;
        end

        if (rst_n && (state == IDLE)) begin
            req0_ready = !grant && req0_valid;
            req1_ready = grant && req1_valid;
        end

        accept = req0_ready | req1_ready;

        case (state)
            IDLE:    if (accept) next_state = SETTLE;
            SETTLE:  if (settle_cnt == 4'd0) next_state = RESP;
            RESP:    if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // add_a/add_b only change on an accept. This keeps the adder inputs
    // steady through SETTLE and RESP, and until the next request is taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            add_a      <= 16'd0;
            add_b      <= 16'd0;
            rsp_id     <= 1'b0;
            rsp_sum    <= 16'd0;
            rsp_co     <= 1'b0;
            settle_cnt <= 4'd0;
            last_grant <= 1'b1;
        end else begin
            if (accept) begin
                add_a      <= grant ? req1_a : req0_a;
                add_b      <= grant ? req1_b : req0_b;
                rsp_id     <= grant;
                last_grant <= grant;
                settle_cnt <= SETTLE_LOAD;
            end
            if (state == SETTLE) begin
                if (settle_cnt == 4'd0) begin
                    rsp_sum <= sum_capture;
                    rsp_co  <= add_co;
                end else begin
                    settle_cnt <= settle_cnt - 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_adder_arb.sv
// -----------------------------------------------------------------------------
// tb_adder_arb
//
// Self-checking bench for adder_arb. Two instances are used:
//   dut1  SETTLE_CYC=1: table of requests with a response scoreboard
//   dut4  SETTLE_CYC=4: hand sequences for backpressure and for reset
//         asserted mid-SETTLE
// Each instance has its shared adder modelled by a plain 17-bit add.
// -----------------------------------------------------------------------------
module tb_adder_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_acc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    // dut1 signals
    logic        rst_n, req0_valid, req1_valid, req0_ready, req1_ready;
    logic [15:0] req0_a, req0_b, req1_a, req1_b, add_a, add_b, add_s, rsp_sum;
    logic        add_co, rsp_valid, rsp_id, rsp_co, rsp_ready;

    // dut4 signals
    logic        rst_n_4, req0_valid_4, req1_valid_4, req0_ready_4, req1_ready_4;
    logic [15:0] req0_a_4, req0_b_4, req1_a_4, req1_b_4, add_a_4, add_b_4, add_s_4, rsp_sum_4;
    logic        add_co_4, rsp_valid_4, rsp_id_4, rsp_co_4, rsp_ready_4;

    assign {add_co, add_s}     = {1'b0, add_a} + {1'b0, add_b};
    assign {add_co_4, add_s_4} = {1'b0, add_a_4} + {1'b0, add_b_4};

    adder_arb #(.SETTLE_CYC(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .add_a(add_a), .add_b(add_b), .add_s(add_s), .add_co(add_co),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_co(rsp_co),
        .rsp_ready(rsp_ready)
    );

    adder_arb #(.SETTLE_CYC(4)) dut4 (
        .clk(clk), .rst_n(rst_n_4),
        .req0_valid(req0_valid_4), .req1_valid(req1_valid_4),
        .req0_a(req0_a_4), .req0_b(req0_b_4), .req1_a(req1_a_4), .req1_b(req1_b_4),
        .req0_ready(req0_ready_4), .req1_ready(req1_ready_4),
        .add_a(add_a_4), .add_b(add_b_4), .add_s(add_s_4), .add_co(add_co_4),
        .rsp_valid(rsp_valid_4), .rsp_id(rsp_id_4), .rsp_sum(rsp_sum_4), .rsp_co(rsp_co_4),
        .rsp_ready(rsp_ready_4)
    );

    typedef struct {
        logic        v0;
        logic [15:0] a0;
        logic [15:0] b0;
        logic        v1;
        logic [15:0] a1;
        logic [15:0] b1;
        logic        exp_id;
    } vec_t;

    typedef struct {
        logic        id;
        logic [15:0] sum;
        logic        co;
        int          acc_cyc;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[8];

    // Reference add: unsigned modulo 2^16, saturating when the macro is set.
    function automatic logic [16:0] model_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] r;
        r = {1'b0, a} + {1'b0, b};
`ifdef ADDER_ARB_SAT_EN
        if (r[16]) r[15:0] = 16'hFFFF;
`endif
        return r;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Response monitor for dut1. It checks that no ready appears in RESP and
    // that rsp_valid rises one cycle after accept. On each handshake it pops
    // the scoreboard and compares the response.
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            check_output("ready_in_resp", {31'd0, req0_ready | req1_ready}, 32'd0);
            if (!prev_valid && sb.size() > 0)
                check_output("latency", cyc - sb[0].acc_cyc, 32'd1);
            if (rsp_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_rsp actual=id%0d required=none", rsp_id);
                end else begin
                    check_output("rsp_id", {31'd0, rsp_id}, {31'd0, sb[0].id});
                    check_output("rsp_sum", {16'd0, rsp_sum}, {16'd0, sb[0].sum});
                    check_output("rsp_co", {31'd0, rsp_co}, {31'd0, sb[0].co});
                    void'(sb.pop_front());
                end
            end
        end
        prev_valid <= (rsp_valid === 1'b1);
    end

    // Drive one table record, wait (bounded) for a grant, check the grant
    // and the accept spacing, then queue the expected response.
    task automatic apply_stimulus(input vec_t v);
        int          waited;
        logic [16:0] r;
        exp_t        e;
        req0_valid = v.v0;
        req0_a     = v.a0;
        req0_b     = v.b0;
        req1_valid = v.v1;
        req1_a     = v.a1;
        req1_b     = v.b1;
        waited     = 0;
        #1;
        while (!(req0_ready | req1_ready) && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (waited >= 20) begin
            checks++;
            failures++;
            $display("[TB] FAIL grant_timeout actual=no_ready required=ready");
            return;
        end
        check_output("grant_id", {30'd0, req1_ready, req0_ready},
                     v.exp_id ? 32'd2 : 32'd1);
        r = v.exp_id ? model_add(v.a1, v.b1) : model_add(v.a0, v.b0);
        e.id      = v.exp_id;
        e.sum     = r[15:0];
        e.co      = r[16];
        e.acc_cyc = cyc + 1;
        if (last_acc >= 0)
            check_output("throughput", e.acc_cyc - last_acc, 32'd3);
        last_acc = e.acc_cyc;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   n;
        logic bad;

        tbl[0] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 16'h0002, 1'b1};
        tbl[1] = '{1'b1, 16'h0001, 16'h0001, 1'b1, 16'h0002, 16'h0002, 1'b0};
        tbl[2] = '{1'b1, 16'h0001, 16'h0001, 1'b1, 16'h0002, 16'h0002, 1'b1};
        tbl[3] = '{1'b1, 16'h0001, 16'h0001, 1'b1, 16'h0002, 16'h0002, 1'b0};
        tbl[4] = '{1'b1, 16'h1234, 16'h0001, 1'b0, 16'h0000, 16'h0000, 1'b0};
        tbl[5] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h8000, 16'h8000, 1'b1};
        tbl[6] = '{1'b1, 16'hFFFF, 16'h0001, 1'b1, 16'h00FF, 16'h0F00, 1'b0};
        tbl[7] = '{1'b1, 16'hFFFF, 16'h0001, 1'b1, 16'h00FF, 16'h0F00, 1'b1};

        rst_n = 1'b0; rsp_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 16'h1111; req0_b = 16'h2222; req1_a = 16'h3333; req1_b = 16'h4444;
        rst_n_4 = 1'b0; rsp_ready_4 = 1'b1;
        req0_valid_4 = 1'b1; req1_valid_4 = 1'b1;
        req0_a_4 = 16'h0; req0_b_4 = 16'h0; req1_a_4 = 16'h0; req1_b_4 = 16'h0;

        // Reset held for two edges with both requesters valid.
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_output("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        check_output("rst_rsp", {13'd0, rsp_valid, rsp_id, rsp_co, rsp_sum}, 32'd0);
        check_output("rst_add", {add_a, add_b}, 32'd0);
        check_output("rst_ready_4", {30'd0, req1_ready_4, req0_ready_4}, 32'd0);

        // First cycle after release: req0 must win the first arbitration.
        rst_n = 1'b1;
        rst_n_4 = 1'b1;
        req0_valid_4 = 1'b0;
        req1_valid_4 = 1'b0;
        #1;
        check_output("first_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) apply_stimulus(tbl[i]);

        req0_valid = 1'b0;
        req1_valid = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_output("sb_drain", sb.size(), 32'd0);

        // Backpressure on dut4: 4-cycle settle, rsp_ready low for 5 cycles.
        @(negedge clk);
        rsp_ready_4 = 1'b0;
        req0_valid_4 = 1'b1; req0_a_4 = 16'h1111; req0_b_4 = 16'h2222;
        req1_a_4 = 16'h4000; req1_b_4 = 16'h0004;
        #1;
        check_output("bp_grant", {30'd0, req1_ready_4, req0_ready_4}, 32'd1);
        @(posedge clk);
        #1;
        req0_valid_4 = 1'b0;
        req1_valid_4 = 1'b1;
        n = 0;
        bad = 1'b0;
        while (n < 20) begin
            @(posedge clk);
            n++;
            #1;
            if (rsp_valid_4 === 1'b1) break;
            if (req0_ready_4 | req1_ready_4) bad = 1'b1;
        end
        check_output("bp_latency", n, 32'd4);
        check_output("bp_no_ready_settle", {31'd0, bad}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_output("bp_hold",
                {11'd0, rsp_valid_4, rsp_id_4, rsp_co_4, req0_ready_4, req1_ready_4, rsp_sum_4},
                {11'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h3333});
            check_output("bp_add_hold", {add_a_4, add_b_4}, {16'h1111, 16'h2222});
        end
        rsp_ready_4 = 1'b1;
        @(negedge clk);
        check_output("bp_release", {30'd0, rsp_valid_4, req1_ready_4}, 32'd1);
        req1_valid_4 = 1'b0;
        bad = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid_4 !== 1'b0) bad = 1'b1;
        end
        check_output("dropped_req", {31'd0, bad}, 32'd0);

        // Reset mid-SETTLE: last grant is req0 here, so after a correct reset
        // req0 must still win against req1.
        req0_valid_4 = 1'b1; req0_a_4 = 16'h0101; req0_b_4 = 16'h0202;
        #1;
        check_output("rs_grant", {30'd0, req1_ready_4, req0_ready_4}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst_n_4 = 1'b0;
        req1_valid_4 = 1'b1;
        #1;
        check_output("rs_ready_in_rst", {30'd0, req1_ready_4, req0_ready_4}, 32'd0);
        @(negedge clk);
        check_output("rs_no_rsp", {31'd0, rsp_valid_4}, 32'd0);
        rst_n_4 = 1'b1;
        #1;
        check_output("rs_regrant", {30'd0, req1_ready_4, req0_ready_4}, 32'd1);
        req0_valid_4 = 1'b0;
        req1_valid_4 = 1'b0;
        bad = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid_4 !== 1'b0) bad = 1'b1;
        end
        check_output("rs_abandoned", {31'd0, bad}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
